// File: rtl/adc_scan_controller.sv
// adc_scan_controller
//   Sweeps a set of serial ADCs that share one sclk and have their own cs_n
//   and sdata lines. Each selected channel goes through a track phase, a run
//   of leading-zero clocks and an MSB-first data read. The result is offset
//   corrected, windowed, optionally inverted, and written to a downstream FIFO.
//
//   Optional feature: define ADC_SATURATE_EN to clamp instead of wrap. A
//   negative difference becomes 0, and a difference above the output window
//   becomes all ones (the clamp is applied before inversion).
//
// Ports
//   clk, reset           clock; synchronous active-high reset
//   capture_start        single-cycle sweep request
//   channel_mask         channels converted per sweep (latched at sweep start)
//   track_counts         track duration in clk cycles (0 behaves as 1)
//   offset               value subtracted from every result
//   sdata                serial data, one bit per ADC
//   fifo_full            downstream FIFO cannot accept a write
//   fifo_write_enable    one-cycle write strobe
//   fifo_write_data      processed result
//   fifo_write_chan      channel index of the result
//   sclk                 ADC serial clock (clk/2 while active, idles high)
//   cs_n                 per-ADC chip select, active low, at most one low
//   sample_done          one-cycle pulse at the end of each track phase
//   busy                 high whenever the controller is not idle
//   capture_requested    single-deep pending sweep request
//   adc_state            current state (IDLE=0 TRACK=1 ZEROS=2 READ=3 WAIT_FIFO=4)
module adc_scan_controller #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned DATA_BITS  = 12,
  parameter int unsigned ZERO_BITS  = 3,
  parameter int unsigned OUT_BITS   = 8,
  parameter int unsigned OUT_LSB    = 1,
  parameter int unsigned INVERT     = 1,
  parameter int unsigned TIMER_BITS = 8
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         capture_start,
  input  logic [NUM_CH-1:0]                            channel_mask,
  input  logic [TIMER_BITS-1:0]                        track_counts,
  input  logic [DATA_BITS-1:0]                         offset,
  input  logic [NUM_CH-1:0]                            sdata,
  input  logic                                         fifo_full,
  output logic                                         fifo_write_enable,
  output logic [OUT_BITS-1:0]                          fifo_write_data,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] fifo_write_chan,
  output logic                                         sclk,
  output logic [NUM_CH-1:0]                            cs_n,
  output logic                                         sample_done,
  output logic                                         busy,
  output logic                                         capture_requested,
  output logic [2:0]                                   adc_state
);

  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CNT_MN = $clog2(2 * (DATA_BITS + ZERO_BITS) + 2);
  localparam int unsigned CNT_W  = (TIMER_BITS > CNT_MN) ? TIMER_BITS : CNT_MN;
`ifdef ADC_SATURATE_EN
  localparam int unsigned WIN_TOP = OUT_LSB + OUT_BITS;
`endif

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_TRACK     = 3'd1;
  localparam logic [2:0] S_ZEROS     = 3'd2;
  localparam logic [2:0] S_READ      = 3'd3;
  localparam logic [2:0] S_WAIT_FIFO = 3'd4;

  localparam logic [CNT_W-1:0] ZERO_LAST = CNT_W'(2 * ZERO_BITS - 1);
  localparam logic [CNT_W-1:0] READ_LAST = CNT_W'(2 * DATA_BITS);

  logic [2:0]           state, state_d;
  logic [CNT_W-1:0]     timer, timer_d;
  logic [NUM_CH-1:0]    mask, mask_d;
  logic [CH_W-1:0]      ch, ch_d;
  logic [DATA_BITS-1:0] data, data_d;
  logic [OUT_BITS-1:0]  result, result_d;
  logic                 req_d, sclk_d, we_d, sd_d, busy_d;
  logic [NUM_CH-1:0]    cs_n_d;
  logic [OUT_BITS-1:0]  wdata_d;
  logic [CH_W-1:0]      wchan_d;

  logic [CNT_W-1:0]     track_last;
  logic [DATA_BITS-1:0] diff;
  logic [OUT_BITS-1:0]  window, processed;
  logic [CH_W:0]        first_sel, next_sel;
  logic                 handoff;
  logic [OUT_BITS-1:0]  hand_value;

  // Lowest set bit of m at or above index from; returns {valid, index}.
  function automatic logic [CH_W:0] find_set(input logic [NUM_CH-1:0] m, input int from);
    logic [CH_W:0] r;
    r = '0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (m[i] && (i >= from)) r = {1'b1, CH_W'(i)};
    end
    return r;
  endfunction

  assign first_sel = find_set(channel_mask, 0);
  assign next_sel  = find_set(mask, int'(ch) + 1);
  assign adc_state = state;

  // Track length of zero is treated as one cycle.
  always_comb begin
    track_last = '0;
    if (track_counts != '0) track_last = CNT_W'(track_counts) - CNT_W'(1);
  end

  // Offset correction, output window and optional inversion.
  always_comb begin
    diff = data - offset;
`ifdef ADC_SATURATE_EN
    if (data < offset) diff = '0;
    window = OUT_BITS'(diff >> OUT_LSB);
    if ((diff >> WIN_TOP) != '0) window = '1;
`else
    window = OUT_BITS'(diff >> OUT_LSB);
`endif
    processed = (INVERT != 0) ? ~window : window;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state;
    timer_d    = timer;
    mask_d     = mask;
    ch_d       = ch;
    data_d     = data;
    result_d   = result;
    req_d      = capture_requested;
    sclk_d     = sclk;
    cs_n_d     = cs_n;
    we_d       = 1'b0;
    wdata_d    = fifo_write_data;
    wchan_d    = fifo_write_chan;
    sd_d       = 1'b0;
    handoff    = 1'b0;
    hand_value = result;

    if (capture_start && (state != S_IDLE)) req_d = 1'b1;

    case (state)
      S_IDLE: begin
        if (capture_start || capture_requested) begin
          req_d = 1'b0;
          if (first_sel[CH_W]) begin
            state_d = S_TRACK;
            mask_d  = channel_mask;
            ch_d    = first_sel[CH_W-1:0];
            timer_d = '0;
          end
        end
      end
      S_TRACK: begin
        sclk_d = 1'b1;
        cs_n_d = '1;
        if (timer >= track_last) begin
          timer_d = '0;
          sclk_d  = 1'b0;
          cs_n_d  = ~(NUM_CH'(1) << ch);
          sd_d    = 1'b1;
          state_d = (ZERO_BITS == 0) ? S_READ : S_ZEROS;
        end else begin
          timer_d = timer + CNT_W'(1);
        end
      end
      S_ZEROS: begin
        sclk_d = ~sclk;
        if (timer == ZERO_LAST) begin
          state_d = S_READ;
          timer_d = '0;
        end else begin
          timer_d = timer + CNT_W'(1);
        end
      end
      S_READ: begin
        // One extra cycle after the last sample lets the result settle.
        if (timer == READ_LAST) begin
          handoff    = 1'b1;
          hand_value = processed;
        end else begin
          sclk_d  = ~sclk;
          timer_d = timer + CNT_W'(1);
          if (sclk) data_d = DATA_BITS'({data, sdata[ch]});
        end
      end
      S_WAIT_FIFO: begin
        handoff    = 1'b1;
        hand_value = result;
      end
      default: state_d = S_IDLE;
    endcase

    // Result handoff, then next channel, queued sweep or idle.
    if (handoff) begin
      sclk_d   = 1'b1;
      cs_n_d   = '1;
      timer_d  = '0;
      result_d = hand_value;
      if (fifo_full) begin
        state_d = S_WAIT_FIFO;
      end else begin
        we_d    = 1'b1;
        wdata_d = hand_value;
        wchan_d = ch;
        if (next_sel[CH_W]) begin
          state_d = S_TRACK;
          ch_d    = next_sel[CH_W-1:0];
        end else if (capture_requested || capture_start) begin
          req_d = 1'b0;
          if (first_sel[CH_W]) begin
            state_d = S_TRACK;
            mask_d  = channel_mask;
            ch_d    = first_sel[CH_W-1:0];
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_IDLE;
      timer             <= '0;
      mask              <= '0;
      ch                <= '0;
      data              <= '0;
      result            <= '0;
      capture_requested <= 1'b0;
      sclk              <= 1'b1;
      cs_n              <= '1;
      fifo_write_enable <= 1'b0;
      fifo_write_data   <= '0;
      fifo_write_chan   <= '0;
      sample_done       <= 1'b0;
      busy              <= 1'b0;
    end else begin
      state             <= state_d;
      timer             <= timer_d;
      mask              <= mask_d;
      ch                <= ch_d;
      data              <= data_d;
      result            <= result_d;
      capture_requested <= req_d;
      sclk              <= sclk_d;
      cs_n              <= cs_n_d;
      fifo_write_enable <= we_d;
      fifo_write_data   <= wdata_d;
      fifo_write_chan   <= wchan_d;
      sample_done       <= sd_d;
      busy              <= busy_d;
    end
  end

endmodule

// File: tb/tb_adc_scan_controller.sv
// Directed bench for adc_scan_controller with default parameters.
// A behavioural ADC per channel drives sdata from sclk/cs_n.
module tb_adc_scan_controller;

  localparam int NUM_CH    = 2;
  localparam int DATA_BITS = 12;
  localparam int ZERO_BITS = 3;

`ifdef ADC_SATURATE_EN
  localparam logic [7:0] EXP_1024 = 8'h00;
  localparam logic [7:0] EXP_300  = 8'hFF;
`else
  localparam logic [7:0] EXP_1024 = 8'hF2;
  localparam logic [7:0] EXP_300  = 8'h5C;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        capture_start;
  logic [1:0]  channel_mask;
  logic [7:0]  track_counts;
  logic [11:0] offset;
  logic [1:0]  sdata;
  logic        fifo_full;
  logic        fifo_write_enable;
  logic [7:0]  fifo_write_data;
  logic [0:0]  fifo_write_chan;
  logic        sclk;
  logic [1:0]  cs_n;
  logic        sample_done;
  logic        busy;
  logic        capture_requested;
  logic [2:0]  adc_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_BITS-1:0] adc_val [NUM_CH];

  always #5 clk = ~clk;

  adc_scan_controller dut (
    .clk(clk), .reset(reset), .capture_start(capture_start),
    .channel_mask(channel_mask), .track_counts(track_counts), .offset(offset),
    .sdata(sdata), .fifo_full(fifo_full), .fifo_write_enable(fifo_write_enable),
    .fifo_write_data(fifo_write_data), .fifo_write_chan(fifo_write_chan),
    .sclk(sclk), .cs_n(cs_n), .sample_done(sample_done), .busy(busy),
    .capture_requested(capture_requested), .adc_state(adc_state)
  );

  // ADC model: after ZERO_BITS rising sclk edges, present MSB first on each rise.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_adc
    int rcnt = 0;
    logic bitv = 1'b0;
    logic [DATA_BITS-1:0] tmp;
    always @(posedge sclk or posedge cs_n[g]) begin
      if (cs_n[g]) begin
        rcnt = 0;
        bitv = 1'b0;
      end else begin
        rcnt = rcnt + 1;
        if (rcnt > ZERO_BITS && rcnt <= ZERO_BITS + DATA_BITS) begin
          tmp  = adc_val[g] >> (DATA_BITS - (rcnt - ZERO_BITS));
          bitv = tmp[0];
        end else begin
          bitv = 1'b0;
        end
      end
    end
    assign sdata[g] = bitv;
  end

  int wr_cnt, sd_cnt, sd_first, idle_first, both_low, busy_cnt;
  int wr_cyc [4];
  logic [7:0] wr_dat [4];
  logic wr_ch [4];

  task automatic start_sweep();
    capture_start = 1'b1;
    @(posedge clk); #1;
    capture_start = 1'b0;
  endtask

  // Records writes, sample_done pulses and state over ncyc cycles after a start.
  task automatic observe(input int ncyc);
    wr_cnt = 0; sd_cnt = 0; sd_first = -1; idle_first = -1; both_low = 0; busy_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      wr_cyc[i] = -1; wr_dat[i] = 'x; wr_ch[i] = 1'bx;
    end
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk); #1;
      if (fifo_write_enable === 1'b1) begin
        if (wr_cnt < 4) begin
          wr_cyc[wr_cnt] = k; wr_dat[wr_cnt] = fifo_write_data; wr_ch[wr_cnt] = fifo_write_chan[0];
        end
        wr_cnt++;
      end
      if (sample_done === 1'b1) begin
        if (sd_cnt == 0) sd_first = k;
        sd_cnt++;
      end
      if (cs_n === 2'b00) both_low++;
      if (adc_state !== 3'd0) busy_cnt++;
      if (adc_state === 3'd0 && idle_first < 0) idle_first = k;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; capture_start = 1'b0; channel_mask = 2'b01; track_counts = 8'd14;
    offset = 12'd485; fifo_full = 1'b0; adc_val[0] = 12'd1024; adc_val[1] = 12'd300;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (adc_state !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", adc_state); end
    n_checks++; if (sclk !== 1'b1) begin n_fail++; $display("FAIL reset_sclk got %b want 1", sclk); end
    n_checks++; if (cs_n !== 2'b11) begin n_fail++; $display("FAIL reset_cs_n got %b want 11", cs_n); end
    n_checks++; if (fifo_write_enable !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", fifo_write_enable); end
    n_checks++; if (fifo_write_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", fifo_write_data); end
    n_checks++; if (busy !== 1'b0 || sample_done !== 1'b0 || capture_requested !== 1'b0 || fifo_write_chan !== 1'b0)
      begin n_fail++; $display("FAIL reset_misc got busy=%b sd=%b req=%b chan=%b want 0 0 0 0", busy, sample_done, capture_requested, fifo_write_chan); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_latency_modulo();
    channel_mask = 2'b01; adc_val[0] = 12'd1024;
    start_sweep();
    observe(60);
    n_checks++; if (wr_cnt != 1) begin n_fail++; $display("FAIL lat_wr_count got %0d want 1", wr_cnt); end
    n_checks++; if (wr_cyc[0] != 45) begin n_fail++; $display("FAIL lat_cycle got %0d want 45", wr_cyc[0]); end
    n_checks++; if (wr_dat[0] !== EXP_1024) begin n_fail++; $display("FAIL lat_data got %h want %h", wr_dat[0], EXP_1024); end
    n_checks++; if (wr_ch[0] !== 1'b0) begin n_fail++; $display("FAIL lat_chan got %b want 0", wr_ch[0]); end
    n_checks++; if (sd_cnt != 1 || sd_first != 14) begin n_fail++; $display("FAIL lat_sample_done got n=%0d at %0d want 1 at 14", sd_cnt, sd_first); end
    n_checks++; if (idle_first != 45) begin n_fail++; $display("FAIL lat_idle got %0d want 45", idle_first); end
  endtask

  task automatic test_negative_diff();
    channel_mask = 2'b01; adc_val[0] = 12'd300;
    start_sweep();
    observe(60);
    n_checks++; if (wr_cnt != 1 || wr_cyc[0] != 45) begin n_fail++; $display("FAIL neg_write got n=%0d at %0d want 1 at 45", wr_cnt, wr_cyc[0]); end
    n_checks++; if (wr_dat[0] !== EXP_300) begin n_fail++; $display("FAIL neg_data got %h want %h", wr_dat[0], EXP_300); end
  endtask

  task automatic test_two_channels();
    channel_mask = 2'b11; adc_val[0] = 12'd1024; adc_val[1] = 12'd300;
    start_sweep();
    channel_mask = 2'b00;  // must not disturb the running sweep
    observe(120);
    channel_mask = 2'b01;
    n_checks++; if (wr_cnt != 2) begin n_fail++; $display("FAIL two_wr_count got %0d want 2", wr_cnt); end
    n_checks++; if (wr_cyc[0] != 45 || wr_cyc[1] != 90) begin n_fail++; $display("FAIL two_cycles got %0d,%0d want 45,90", wr_cyc[0], wr_cyc[1]); end
    n_checks++; if (wr_ch[0] !== 1'b0 || wr_ch[1] !== 1'b1) begin n_fail++; $display("FAIL two_chans got %b,%b want 0,1", wr_ch[0], wr_ch[1]); end
    n_checks++; if (wr_dat[0] !== EXP_1024 || wr_dat[1] !== EXP_300) begin n_fail++; $display("FAIL two_data got %h,%h want %h,%h", wr_dat[0], wr_dat[1], EXP_1024, EXP_300); end
    n_checks++; if (sd_cnt != 2) begin n_fail++; $display("FAIL two_sample_done got %0d want 2", sd_cnt); end
    n_checks++; if (both_low != 0) begin n_fail++; $display("FAIL two_cs_overlap got %0d cycles want 0", both_low); end
    n_checks++; if (idle_first != 90) begin n_fail++; $display("FAIL two_idle got %0d want 90", idle_first); end
  endtask

  task automatic test_track_zero();
    channel_mask = 2'b01; adc_val[0] = 12'd1024; track_counts = 8'd0;
    start_sweep();
    observe(50);
    track_counts = 8'd14;
    n_checks++; if (sd_first != 1) begin n_fail++; $display("FAIL tz_sample_done got %0d want 1", sd_first); end
    n_checks++; if (wr_cnt != 1 || wr_cyc[0] != 32) begin n_fail++; $display("FAIL tz_write got n=%0d at %0d want 1 at 32", wr_cnt, wr_cyc[0]); end
  endtask

  task automatic test_fifo_full();
    int wcyc, wcount;
    logic [7:0] wdat;
    wcyc = -1; wcount = 0; wdat = 'x;
    channel_mask = 2'b01; adc_val[0] = 12'd1024; fifo_full = 1'b1;
    start_sweep();
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk); #1;
      if (fifo_write_enable === 1'b1) begin
        if (wcount == 0) begin wcyc = k; wdat = fifo_write_data; end
        wcount++;
      end
      if (k >= 45 && k <= 54) begin
        n_checks++;
        if (adc_state !== 3'd4 || sclk !== 1'b1 || cs_n !== 2'b11 || fifo_write_enable !== 1'b0) begin
          n_fail++;
          $display("FAIL ff_hold k=%0d got state=%0d sclk=%b cs_n=%b we=%b want 4 1 11 0", k, adc_state, sclk, cs_n, fifo_write_enable);
        end
        if (k == 54) fifo_full = 1'b0;
      end
    end
    n_checks++; if (wcount != 1 || wcyc != 55) begin n_fail++; $display("FAIL ff_write got n=%0d at %0d want 1 at 55", wcount, wcyc); end
    n_checks++; if (wdat !== EXP_1024) begin n_fail++; $display("FAIL ff_data got %h want %h", wdat, EXP_1024); end
  endtask

  task automatic test_back_to_back();
    int wcount, early_idle;
    int wc [2];
    wcount = 0; early_idle = 0; wc[0] = -1; wc[1] = -1;
    channel_mask = 2'b01; adc_val[0] = 12'd1024;
    start_sweep();
    for (int k = 1; k <= 150; k++) begin
      @(posedge clk); #1;
      if (fifo_write_enable === 1'b1) begin
        if (wcount < 2) wc[wcount] = k;
        wcount++;
      end
      if (k < 90 && adc_state === 3'd0) early_idle++;
      if (k == 6) begin
        n_checks++; if (capture_requested !== 1'b1) begin n_fail++; $display("FAIL b2b_req_set got %b want 1", capture_requested); end
      end
      if (k == 46) begin
        n_checks++; if (capture_requested !== 1'b0) begin n_fail++; $display("FAIL b2b_req_clear got %b want 0", capture_requested); end
      end
      if (k == 91) begin
        n_checks++; if (adc_state !== 3'd0) begin n_fail++; $display("FAIL b2b_final_idle got %0d want 0", adc_state); end
      end
      capture_start = (k == 5 || k == 10 || k == 20);
    end
    capture_start = 1'b0;
    n_checks++; if (wcount != 2 || wc[0] != 45 || wc[1] != 90) begin n_fail++; $display("FAIL b2b_writes got n=%0d at %0d,%0d want 2 at 45,90", wcount, wc[0], wc[1]); end
    n_checks++; if (early_idle != 0) begin n_fail++; $display("FAIL b2b_idle_gap got %0d idle cycles want 0", early_idle); end
  endtask

  task automatic test_reset_mid_read();
    int wbefore;
    wbefore = 0;
    channel_mask = 2'b01; adc_val[0] = 12'd1024;
    start_sweep();
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (fifo_write_enable === 1'b1) wbefore++;
    end
    n_checks++; if (adc_state !== 3'd3) begin n_fail++; $display("FAIL rmr_in_read got %0d want 3", adc_state); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_checks++; if (adc_state !== 3'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL rmr_state got %0d busy=%b want 0 0", adc_state, busy); end
    n_checks++; if (sclk !== 1'b1 || cs_n !== 2'b11) begin n_fail++; $display("FAIL rmr_pins got sclk=%b cs_n=%b want 1 11", sclk, cs_n); end
    n_checks++; if (fifo_write_data !== 8'h00 || fifo_write_chan !== 1'b0 || fifo_write_enable !== 1'b0 || sample_done !== 1'b0)
      begin n_fail++; $display("FAIL rmr_outputs got data=%h chan=%b we=%b sd=%b want 00 0 0 0", fifo_write_data, fifo_write_chan, fifo_write_enable, sample_done); end
    observe(60);
    n_checks++; if (wr_cnt + wbefore != 0 || busy_cnt != 0) begin n_fail++; $display("FAIL rmr_no_write got writes=%0d busy=%0d want 0 0", wr_cnt + wbefore, busy_cnt); end
  endtask

  task automatic test_zero_mask();
    channel_mask = 2'b00;
    start_sweep();
    observe(20);
    n_checks++; if (wr_cnt != 0 || busy_cnt != 0) begin n_fail++; $display("FAIL zm_idle got writes=%0d busy=%0d want 0 0", wr_cnt, busy_cnt); end
    n_checks++; if (capture_requested !== 1'b0) begin n_fail++; $display("FAIL zm_req got %b want 0", capture_requested); end
  endtask

  initial begin
    test_reset();
    test_latency_modulo();
    test_negative_diff();
    test_two_channels();
    test_track_zero();
    test_fifo_full();
    test_back_to_back();
    test_reset_mid_read();
    test_zero_mask();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_scan_controller.md
ADC_SCAN_CONTROLLER -- requirements
Module: adc_scan_controller

Interface
REQ-001 Parameter NUM_CH, 2, number of ADCs sharing sclk, each with own cs_n and sdata.
REQ-002 Parameter DATA_BITS, 12, conversion result width, MSB first.
REQ-003 Parameter ZERO_BITS, 3, leading zero sclk periods before the first data bit.
REQ-004 Parameter OUT_BITS, 8, FIFO data width.
REQ-005 Parameter OUT_LSB, 1, lowest result bit placed in the output window.
REQ-006 Parameter INVERT, 1, 1 = output window bitwise inverted.
REQ-007 Parameter TIMER_BITS, 8, width of track_counts and internal timer.
REQ-008 clk  input  1  clock; reset  input  1  reset, synchronous, active-high.
REQ-009 capture_start  input  1  single-cycle sweep request.
REQ-010 channel_mask  input  NUM_CH  channels converted per sweep, sampled at sweep start.
REQ-011 track_counts  input  TIMER_BITS  track duration in clk cycles.
REQ-012 offset  input  DATA_BITS  value subtracted from each result.
REQ-013 sdata  input  NUM_CH  serial data, one bit per ADC.
REQ-014 fifo_full  input  1  downstream FIFO cannot accept a write.
REQ-015 fifo_write_enable  output  1  one-cycle write strobe.
REQ-016 fifo_write_data  output  OUT_BITS  processed result.
REQ-017 fifo_write_chan  output  max(1,clog2(NUM_CH))  channel index of the result.
REQ-018 sclk  output  1  ADC serial clock, clk/2 while active, idles high.
REQ-019 cs_n  output  NUM_CH  per-ADC chip select, active low, at most one low.
REQ-020 sample_done  output  1  one-cycle pulse at end of each track phase.
REQ-021 busy  output  1  high in any state other than IDLE.
REQ-022 capture_requested  output  1  pending-request flag; adc_state  output  3  current state (IDLE=0,TRACK=1,ZEROS=2,READ=3,WAIT_FIFO=4).

Function
REQ-023 All outputs SHALL be registered.
REQ-024 IDLE: on capture_start or capture_requested with channel_mask nonzero, SHALL latch mask, select lowest set channel, clear request, enter TRACK, timer=0; mask zero consumes the request and remains in IDLE.
REQ-025 TRACK: sclk and cs_n high for max(track_counts,1) cycles; on exit drive selected cs_n low, sclk low, pulse sample_done, enter ZEROS.
REQ-026 ZEROS: cs_n low, sclk toggles every clk, lasts 2*ZERO_BITS cycles, then READ.
REQ-027 READ: sclk toggles; while sclk is high SHALL sample sdata[ch] into bit DATA_BITS-1-n, n counting 0..DATA_BITS-1.
REQ-028 After the last bit: diff = data - offset modulo 2^DATA_BITS; window = diff[OUT_LSB+OUT_BITS-1:OUT_LSB]; output = INVERT ? ~window : window.
REQ-029 Result handoff: if fifo_full low, pulse fifo_write_enable with data and chan, cs_n and sclk high; else enter WAIT_FIFO holding result, cs_n and sclk high, retrying every cycle.
REQ-030 After handoff SHALL proceed to next higher set bit of latched mask (TRACK); else new sweep if request pending; else IDLE.
REQ-031 capture_start while busy SHALL set capture_requested; further requests coalesce (single-deep).
REQ-032 Latency: fifo_write_enable high exactly 1+T+2*ZERO_BITS+2*DATA_BITS cycles after the edge sampling capture_start from IDLE (T = max(track_counts,1)), fifo not full.
REQ-033 channel_mask changes mid-sweep SHALL not affect the current sweep.

Reset
REQ-034 Reset SHALL force IDLE, timer 0, capture_requested 0, data 0, fifo_write_enable 0, sample_done 0, fifo_write_data 0, fifo_write_chan 0, sclk 1, cs_n all 1, on the next edge, including mid-conversion.

Configuration
REQ-035 ADC_SATURATE_EN defined: diff clamps to 0 when data < offset and window clamps to all ones when diff >= 2^(OUT_LSB+OUT_BITS), before inversion; undefined: modulo arithmetic of REQ-028 only.

Verification
REQ-036 Defaults, mask=01, track=14, offset=485, sdata=1024 -> one write, chan 0, at cycle 45; data 0xF2 without macro, 0x00 with ADC_SATURATE_EN.
REQ-037 sdata=300, offset=485 -> data 0x5C without macro, 0xFF with macro.
REQ-038 mask=11, one start -> two writes, chan 0 then 1, two sample_done pulses, never both cs_n low.
REQ-039 fifo_full held 10 cycles at handoff -> state 4, no write, sclk/cs_n high; write on first cycle full is low, data unchanged.
REQ-040 Three starts during a sweep -> exactly one extra sweep, back-to-back via TRACK without IDLE.
REQ-041 Reset asserted during READ -> next cycle all reset values, no write; mask=00 start -> stays IDLE, no write.
